// File: rtl/push_credit_dispatcher_pkg.sv
// Shared types and helpers for the push credit dispatcher.
// Holds the FSM state encoding plus small width/one-hot utilities.
package push_credit_dispatcher_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic onehot_or_zero(input logic [31:0] v);
        return (v & (v - 32'd1)) == 32'd0;
    endfunction

endpackage

// File: rtl/push_credit_dispatcher_credit_counter.sv
// Saturating credit counter mirroring one downstream FIFO's free slots.
// Reset value is DEPTH; simultaneous inc and dec cancel.
module credit_counter #(
    parameter int DEPTH    = 8,
    parameter int CNTWIDTH = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                dec,
    output logic [CNTWIDTH-1:0] cnt,
    output logic                at_max,
    output logic                at_zero,
    output logic                ovf
);

    localparam logic [CNTWIDTH-1:0] MAX = CNTWIDTH'(DEPTH);

    assign at_max  = (cnt == MAX);
    assign at_zero = (cnt == '0);
    // A return while already full is a protocol error even if a dec cancels it.
    assign ovf     = inc & at_max;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= MAX;
        end else if (inc & ~dec & ~at_max) begin
            cnt <= cnt + CNTWIDTH'(1);
        end else if (dec & ~inc & ~at_zero) begin
            cnt <= cnt - CNTWIDTH'(1);
        end
    end

endmodule

// File: rtl/push_credit_dispatcher.sv
// Credit-gated dispatcher feeding NUM_FIFOS downstream FIFOs, with flush/drain sequencing.
// state | meaning:  RUN = accepting words,  DRAIN = waiting for all credits back,  DONE = drained, flush_done high
module push_credit_dispatcher
    import push_credit_dispatcher_pkg::*;
#(
    parameter int NUM_FIFOS = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int TAGWIDTH  = $clog2(NUM_FIFOS),
    parameter int CNTWIDTH  = cnt_width(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_vld,
    input  logic [TAGWIDTH-1:0]  in_tag,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_rdy,
    input  logic [NUM_FIFOS-1:0] gnt,
    output logic                 push,
    output logic [TAGWIDTH-1:0]  push_sel,
    output logic [WIDTH-1:0]     data_out,
    input  logic                 flush,
    output logic                 flush_done,
    output logic                 err
);

    state_t                state;
    logic                  accept;
    logic                  tag_has_credit;
    logic                  all_full_next;
    logic [NUM_FIFOS-1:0]  gnt_low;
    logic [NUM_FIFOS-1:0]  inc;
    logic [NUM_FIFOS-1:0]  dec;
    logic [NUM_FIFOS-1:0]  at_max;
    logic [NUM_FIFOS-1:0]  at_zero;
    logic [NUM_FIFOS-1:0]  ovf;
    logic [NUM_FIFOS-1:0]  full_next;
    logic [CNTWIDTH-1:0]   cnt [NUM_FIFOS];

    // Only the lowest grant bit is credited when gnt is malformed.
    assign gnt_low = gnt & (~gnt + NUM_FIFOS'(1));

    generate
        for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_credit
            assign inc[i] = gnt_low[i];
            assign dec[i] = accept & (in_tag == TAGWIDTH'(i));

            credit_counter #(
                .DEPTH    (DEPTH),
                .CNTWIDTH (CNTWIDTH)
            ) u_credit (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc[i]),
                .dec     (dec[i]),
                .cnt     (cnt[i]),
                .at_max  (at_max[i]),
                .at_zero (at_zero[i]),
                .ovf     (ovf[i])
            );

            assign full_next[i] = (at_max[i] & (inc[i] | ~dec[i]))
                                | ((cnt[i] == CNTWIDTH'(DEPTH - 1)) & inc[i] & ~dec[i]);
        end
    endgenerate

    assign all_full_next = &full_next;

    // Tags outside 0..NUM_FIFOS-1 match no counter and are never ready.
    always_comb begin
        tag_has_credit = 1'b0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (in_tag == TAGWIDTH'(i)) begin
                tag_has_credit = ~at_zero[i];
            end
        end
    end

    assign in_rdy = (state == RUN) & rst & tag_has_credit;
    assign accept = in_vld & in_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            push     <= 1'b0;
            push_sel <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            push <= accept;
            if (accept) begin
                push_sel <= in_tag;
                data_out <= in_data;
            end
            if ((|ovf) | ~onehot_or_zero(32'(gnt))) begin
                err <= 1'b1;
            end
        end
    end

    // DONE is entered on the edge where credits become full, so flush_done
    // rises the cycle right after the last returning grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= RUN;
            flush_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (flush) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (all_full_next & ~accept) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        state      <= RUN;
                        flush_done <= 1'b0;
                    end
                end
                default: begin
                    state      <= RUN;
                    flush_done <= 1'b0;
                end
            endcase
        end
    end

    a_no_push_to_full: assert property (@(posedge clk) disable iff (!rst)
        !(|(dec & at_zero)));
    a_done_all_empty: assert property (@(posedge clk) disable iff (!rst)
        (state == DONE) |-> (&at_max));
    a_single_credit: assert property (@(posedge clk) disable iff (!rst)
        onehot_or_zero(32'(gnt_low)));

endmodule
